// File: rtl/trigger_pkg.sv
// Shared types and constants for the self-triggering acquisition controller.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
//
// Contents:
//   trig_state_t - controller phase (FILL, ARMED, ACQUIRE, DRAIN)
//   LANE_WIDTH   - bits per ADC lane on the stream bus
//   N_LANES      - lanes on the default 128-bit bus
//   lanes_of()   - lanes for an arbitrary bus width
//   thr_level()  - threshold percentage of full scale to a 12-bit level
//   cnt_width()  - counter width able to hold 0..max_val
package trigger_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        ARMED   = 2'd1,
        ACQUIRE = 2'd2,
        DRAIN   = 2'd3
    } trig_state_t;

    localparam int LANE_WIDTH       = 16;
    localparam int DEF_TDATA_WIDTH  = 128;
    localparam int N_LANES          = DEF_TDATA_WIDTH / LANE_WIDTH;
    localparam int FULL_SCALE       = 1 << 12;

    function automatic int lanes_of(input int tdata_width);
        return tdata_width / LANE_WIDTH;
    endfunction

    // Percentage of 2^12, rounded down (10 % -> 409).
    function automatic int thr_level(input int threshold_pct);
        return (threshold_pct * FULL_SCALE) / 100;
    endfunction

    // Always at least one bit so a zero-length window still elaborates.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/trigger_ctrl_lane_threshold_cmp.sv
// Compares every signed ADC sample of one stream beat against a positive level.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller qualifies hit_any with the beat handshake.
//
// Ports:
//   tdata   in  TDATA_WIDTH  stream beat, one sample left-justified per 16-bit lane
//   hit_any out 1            some sample is strictly greater than +LEVEL
module lane_threshold_cmp
    import trigger_pkg::*;
#(
    parameter int TDATA_WIDTH  = 128,
    parameter int SAMPLE_WIDTH = 12,
    parameter int LEVEL        = 409
) (
    input  logic [TDATA_WIDTH-1:0] tdata,
    output logic                   hit_any
);

    localparam int NUM_LANES = lanes_of(TDATA_WIDTH);

    logic [NUM_LANES-1:0] lane_hit;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic signed [SAMPLE_WIDTH-1:0] sample;

        // The converter left-justifies samples; the low lane bits are padding.
        assign sample      = tdata[k*LANE_WIDTH + LANE_WIDTH - 1 -: SAMPLE_WIDTH];
        // Sign-extend to 32 bits so levels at or above 2^(SAMPLE_WIDTH-1)
        // still compare correctly (such a level can never be exceeded).
        assign lane_hit[k] = (int'(sample) > LEVEL);

        if (LANE_WIDTH > SAMPLE_WIDTH) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^tdata[k*LANE_WIDTH +: LANE_WIDTH - SAMPLE_WIDTH];
        end
    end

    assign hit_any = |lane_hit;

endmodule

// File: rtl/trigger_ctrl.sv
// Self-triggering acquisition controller in front of the capture/DMA path.
// Latency: TRIGGERD_FLAG/TIME_STAMP update one edge after the accepted hit beat.
// Backpressure: monitor only; it never stalls either stream, it vetoes triggers on FIFO_FULL.
//
// Ports:
//   AXIS_ACLK      in   1     sole clock, rising edge
//   AXIS_ARESET    in   1     asynchronous active-high reset
//   S_AXIS_TDATA   in   128   ADC beat, 8 x 16-bit lanes, sample in lane[15:4]
//   S_AXIS_TVALID  in   1     beat valid
//   S_AXIS_TREADY  in   1     beat ready (observed, not driven)
//   ENABLE         in   1     permits triggering while armed
//   FIFO_FULL      in   1     capture FIFO full; turns a trigger into a drop
//   M_AXIS_TVALID/TREADY/TLAST in 1 each  DMA stream handshake, ends the drain
//   TRIGGERD_FLAG  out  1     post-trigger acquisition window
//   TIME_STAMP     out  TIME_STAMP_WIDTH  ts_cnt captured on the trigger edge
//   BUSY           out  1     low only while armed
//   EVENT_CNT      out  16    accepted triggers, wraps
//   DROP_CNT       out  16    vetoed triggers, saturates
//   OVERFLOW       out  1     sticky: FIFO_FULL seen while acquiring
module trigger_ctrl
    import trigger_pkg::*;
#(
    parameter int THRESHOLD            = 10,
    parameter int PRE_ACQUI_LEN        = 12,
    parameter int POST_ACQUI_LEN       = 38,
    parameter int TIME_STAMP_WIDTH     = 16,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int S_AXIS_TDATA_WIDTH   = 128
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TREADY,
    input  logic                          ENABLE,
    input  logic                          FIFO_FULL,
    input  logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    input  logic                          M_AXIS_TLAST,
    output logic                          TRIGGERD_FLAG,
    output logic [TIME_STAMP_WIDTH-1:0]   TIME_STAMP,
    output logic                          BUSY,
    output logic [15:0]                   EVENT_CNT,
    output logic [15:0]                   DROP_CNT,
    output logic                          OVERFLOW
);

    localparam int THR_LEVEL = thr_level(THRESHOLD);
    localparam int MAX_LEN   = (PRE_ACQUI_LEN > POST_ACQUI_LEN) ? PRE_ACQUI_LEN : POST_ACQUI_LEN;
    localparam int CNT_W     = cnt_width(MAX_LEN);

    // Value of the beat counter on the last beat of each counted phase.
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PRE_ACQUI_LEN  > 0) ? PRE_ACQUI_LEN  - 1 : 0);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'((POST_ACQUI_LEN > 0) ? POST_ACQUI_LEN - 1 : 0);

    localparam logic [CNT_W-1:0]            CNT_ONE = 1;
    localparam logic [TIME_STAMP_WIDTH-1:0] TS_ONE  = 1;
    localparam logic [15:0]                 STAT_ONE = 16'd1;

    trig_state_t                 state;
    logic [CNT_W-1:0]            beat_cnt;
    logic [TIME_STAMP_WIDTH-1:0] ts_cnt;

    logic hit_any;
    logic beat_acc;
    logic trig_req;
    logic drain_done;

    lane_threshold_cmp #(
        .TDATA_WIDTH  (S_AXIS_TDATA_WIDTH),
        .SAMPLE_WIDTH (ADC_RESOLUTION_WIDTH),
        .LEVEL        (THR_LEVEL)
    ) u_cmp (
        .tdata   (S_AXIS_TDATA),
        .hit_any (hit_any)
    );

    assign beat_acc   = S_AXIS_TVALID & S_AXIS_TREADY;
    assign trig_req   = beat_acc & hit_any & ENABLE;
    assign drain_done = M_AXIS_TVALID & M_AXIS_TREADY & M_AXIS_TLAST;

    // Single FSM block: every output is a register so the capture buffer
    // sees glitch-free flags, and the flag/timestamp/event count all move
    // on the same edge as the ARMED->ACQUIRE transition.
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state         <= FILL;
            beat_cnt      <= '0;
            ts_cnt        <= '0;
            TRIGGERD_FLAG <= 1'b0;
            TIME_STAMP    <= '0;
            BUSY          <= 1'b1;
            EVENT_CNT     <= '0;
            DROP_CNT      <= '0;
            OVERFLOW      <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_ONE;

            case (state)
                // Let the pre-trigger history refill before arming; hits
                // here are deliberately ignored, including on the last beat.
                FILL: begin
                    if (PRE_ACQUI_LEN == 0) begin
                        state <= ARMED;
                        BUSY  <= 1'b0;
                    end else if (beat_acc) begin
                        if (beat_cnt == PRE_LAST) begin
                            state    <= ARMED;
                            BUSY     <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end

                ARMED: begin
                    if (trig_req) begin
                        if (FIFO_FULL) begin
                            if (DROP_CNT != 16'hFFFF) begin
                                DROP_CNT <= DROP_CNT + STAT_ONE;
                            end
                        end else begin
                            state         <= ACQUIRE;
                            BUSY          <= 1'b1;
                            TRIGGERD_FLAG <= 1'b1;
                            TIME_STAMP    <= ts_cnt;
                            EVENT_CNT     <= EVENT_CNT + STAT_ONE;
                        end
                    end
                end

                // The hit beat was consumed in ARMED, so counting starts
                // with the first accept after the trigger edge.
                ACQUIRE: begin
                    if (FIFO_FULL) begin
                        OVERFLOW <= 1'b1;
                    end
                    if (POST_ACQUI_LEN == 0) begin
                        state         <= DRAIN;
                        TRIGGERD_FLAG <= 1'b0;
                    end else if (beat_acc) begin
                        if (beat_cnt == POST_LAST) begin
                            state         <= DRAIN;
                            TRIGGERD_FLAG <= 1'b0;
                            beat_cnt      <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end

                // Hold off re-arming until the event's last DMA beat has left.
                DRAIN: begin
                    if (drain_done) begin
                        state    <= FILL;
                        beat_cnt <= '0;
                    end
                end

                default: begin
                    state <= FILL;
                    BUSY  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Randomized self-checking bench for trigger_ctrl against a phase-level reference model.
// Latency: model predicts outputs one edge after inputs are applied.
// Backpressure: bench drives TVALID/TREADY/FIFO_FULL freely to exercise stalls and vetoes.
module tb_trigger_ctrl;

    localparam int THR  = (10 * 4096) / 100;   // 409
    localparam int PRE  = 12;
    localparam int POST = 38;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] tdata;
    logic         tvalid, tready, enable, fifo_full;
    logic         m_vld, m_rdy, m_last;
    logic         trig_flag, busy, overflow;
    logic [15:0]  time_stamp, event_cnt, drop_cnt;

    always #5 clk = ~clk;

    trigger_ctrl #(
        .THRESHOLD            (10),
        .PRE_ACQUI_LEN        (PRE),
        .POST_ACQUI_LEN       (POST),
        .TIME_STAMP_WIDTH     (16),
        .ADC_RESOLUTION_WIDTH (12),
        .S_AXIS_TDATA_WIDTH   (128)
    ) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESET   (rst),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TREADY (tready),
        .ENABLE        (enable),
        .FIFO_FULL     (fifo_full),
        .M_AXIS_TVALID (m_vld),
        .M_AXIS_TREADY (m_rdy),
        .M_AXIS_TLAST  (m_last),
        .TRIGGERD_FLAG (trig_flag),
        .TIME_STAMP    (time_stamp),
        .BUSY          (busy),
        .EVENT_CNT     (event_cnt),
        .DROP_CNT      (drop_cnt),
        .OVERFLOW      (overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_in_fill, m_in_win, m_in_drain, m_flag, m_ovf;
    int m_need, m_win_left, m_ts, m_ts_lat, m_events, m_drops;

    function automatic bit beat_hits(input logic [127:0] d);
        for (int k = 0; k < 8; k++) begin
            logic signed [11:0] s;
            s = d[16*k+4 +: 12];
            if (int'(s) > THR) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_in_fill = 1; m_need = PRE; m_in_win = 0; m_win_left = 0; m_in_drain = 0;
        m_flag = 0; m_ovf = 0; m_ts = 0; m_ts_lat = 0; m_events = 0; m_drops = 0;
    endtask

    task automatic model_edge();
        bit acc, hit;
        acc = tvalid && tready;
        hit = acc && beat_hits(tdata);
        if (m_in_fill) begin
            if (acc) m_need--;
            if (m_need <= 0) m_in_fill = 0;
        end else if (m_in_win) begin
            if (fifo_full) m_ovf = 1;
            if (acc) m_win_left--;
            if (m_win_left <= 0) begin
                m_in_win = 0; m_in_drain = 1; m_flag = 0;
            end
        end else if (m_in_drain) begin
            if (m_vld && m_rdy && m_last) begin
                m_in_drain = 0; m_in_fill = 1; m_need = PRE;
            end
        end else if (hit && enable) begin
            if (fifo_full) begin
                if (m_drops < 65535) m_drops++;
            end else begin
                m_in_win = 1; m_win_left = POST; m_flag = 1;
                m_ts_lat = m_ts; m_events = (m_events + 1) % 65536;
            end
        end
        m_ts = (m_ts + 1) % 65536;
    endtask

    function automatic bit model_armed();
        return !(m_in_fill || m_in_win || m_in_drain);
    endfunction

    task automatic compare_all();
        check("flag",     trig_flag,  m_flag);
        check("busy",     busy,       !model_armed());
        check("ts",       time_stamp, m_ts_lat);
        check("events",   event_cnt,  m_events);
        check("drops",    drop_cnt,   m_drops);
        check("overflow", overflow,   m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        compare_all();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] quiet_beat();
        logic [127:0] d;
        for (int k = 0; k < 8; k++) begin
            int v;
            logic [11:0] v12;
            v   = int'($urandom_range(2457, 0)) - 2048;   // -2048..+409
            v12 = v[11:0];
            d[16*k +: 16] = {v12, 4'($urandom)};
        end
        return d;
    endfunction

    function automatic logic [127:0] hot_beat();
        logic [127:0] d;
        int k, v;
        logic [11:0] v12;
        d   = quiet_beat();
        k   = int'($urandom_range(7, 0));
        v   = int'($urandom_range(2047, THR + 1));
        v12 = v[11:0];
        d[16*k +: 16] = {v12, 4'($urandom)};
        return d;
    endfunction

    task automatic idle_m();
        m_vld = 0; m_rdy = 0; m_last = 0;
    endtask

    task automatic finish_window();
        int budget = 500;
        tvalid = 1; tready = 1;
        while (m_in_win && budget > 0) begin
            tdata = quiet_beat(); step(); budget--;
        end
        if (budget == 0) check("window_timeout", 0, 1);
    endtask

    task automatic rearm();
        int budget = 200;
        tvalid = 1; tready = 1; tdata = quiet_beat();
        m_vld = 1; m_rdy = 1; m_last = 1;
        step();
        idle_m();
        while (!model_armed() && budget > 0) begin
            tdata = quiet_beat(); step(); budget--;
        end
        if (budget == 0) check("arm_timeout", 0, 1);
    endtask

    initial begin
        int acc_n, cyc_n, budget;

        rst = 1; tdata = '0; tvalid = 0; tready = 0; enable = 1; fifo_full = 0;
        idle_m();
        model_reset();
        repeat (3) step();
        check("rst_flag",  trig_flag, 0);
        check("rst_busy",  busy,      1);
        check("rst_event", event_cnt, 0);
        check("rst_ts",    time_stamp, 0);
        rst = 0;

        // Fill with quiet beats, then a +410 sample on lane 3.
        tvalid = 1; tready = 1;
        for (int i = 0; i < PRE; i++) begin
            tdata = quiet_beat(); step();
        end
        check("armed_busy", busy, 0);
        tdata = '0; tdata[63:48] = 16'h19A0;
        step();
        check("first_flag",  trig_flag,  1);
        check("first_ts",    time_stamp, 12);
        check("first_event", event_cnt,  1);

        // Window with TVALID toggling; hits inside the window are ignored.
        acc_n = 0; cyc_n = 0;
        while (trig_flag && cyc_n < 500) begin
            tvalid = cyc_n[0];
            tdata  = hot_beat();
            if (tvalid && tready) acc_n++;
            step();
            if (trig_flag) check("win_busy", busy, 1);
            cyc_n++;
        end
        check("win_accepts", acc_n, POST);
        check("win_cycles",  cyc_n, 2 * POST);

        // Drain: hits ignored until TLAST handshake.
        tvalid = 1;
        for (int i = 0; i < 5; i++) begin
            tdata = hot_beat(); step();
        end
        check("drain_event", event_cnt, 1);
        rearm();

        // Strict threshold: +409 everywhere does not trigger, +410 does.
        for (int k = 0; k < 8; k++) tdata[16*k +: 16] = 16'h1990;
        step();
        check("thr_409_flag", trig_flag, 0);
        tdata = '0; tdata[127:112] = 16'h19A0;
        step();
        check("thr_410_flag", trig_flag, 1);
        check("second_event", event_cnt, 2);
        finish_window();
        rearm();

        // FIFO-full veto and DROP_CNT saturation.
        fifo_full = 1; enable = 1;
        tdata = hot_beat();
        step();
        check("veto_flag", trig_flag, 0);
        check("veto_drop", drop_cnt,  1);
        for (int i = 0; i < 70000; i++) begin
            tdata = hot_beat(); step();
        end
        check("drop_sat", drop_cnt, 16'hFFFF);

        // Trigger after the timestamp has wrapped; FIFO_FULL during acquire.
        fifo_full = 0; tdata = hot_beat();
        step();
        check("post_wrap_flag", trig_flag, 1);
        fifo_full = 1; tdata = quiet_beat();
        step();
        fifo_full = 0;
        check("overflow_set", overflow, 1);
        finish_window();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tvalid    = ($urandom_range(3, 0) != 0);
            tready    = ($urandom_range(3, 0) != 0);
            enable    = ($urandom_range(7, 0) != 0);
            fifo_full = ($urandom_range(7, 0) == 0);
            tdata     = ($urandom_range(3, 0) == 0) ? hot_beat() : quiet_beat();
            m_vld     = $urandom_range(1, 0);
            m_rdy     = $urandom_range(1, 0);
            m_last    = ($urandom_range(3, 0) == 0);
            step();
        end
        idle_m(); enable = 1; fifo_full = 0; tvalid = 1; tready = 1;

        // Reset in the middle of an acquisition.
        budget = 400;
        while (!m_in_win && budget > 0) begin
            if (m_in_drain) begin m_vld = 1; m_rdy = 1; m_last = 1; end
            else idle_m();
            tdata = model_armed() ? hot_beat() : quiet_beat();
            step(); budget--;
        end
        idle_m();
        if (budget == 0) check("acq_timeout", 0, 1);
        tdata = quiet_beat();
        step(); step();
        check("pre_rst_flag", trig_flag, 1);
        #2 rst = 1;
        #1 check("async_flag_drop", trig_flag, 0);
        check("async_busy", busy, 1);
        model_reset();
        step(); step();
        check("rst_event2",    event_cnt, 0);
        check("rst_drop2",     drop_cnt,  0);
        check("rst_overflow2", overflow,  0);
        rst = 0;
        for (int i = 0; i < PRE; i++) begin
            tdata = quiet_beat(); step();
        end
        check("rearm_after_rst", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
